// File: rtl/nios_audio_sample_out_fifo_if.sv
// ---------------------------------------------------------------------------
// nios_audio_sample_out_fifo_if
// Avalon-MM slave bus bundle for the audio sample output FIFO.
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] combinational read data, zero wait states
// master: the NIOS II side (drives the request); slave: the FIFO block.
// ---------------------------------------------------------------------------
interface nios_audio_sample_out_fifo_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_audio_sample_out_fifo.sv
// ---------------------------------------------------------------------------
// nios_audio_sample_out_fifo
// Software-filled sample FIFO feeding an audio output port. The NIOS II
// pushes samples over Avalon-MM; each sample_tick pops one onto out_port.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   bus          Avalon-MM slave (nios_audio_sample_out_fifo_if.slave)
//   sample_tick  one-cycle pop strobe, synchronous to clk
//   out_port     current sample (DATA_WIDTH bits)
//   underrun     one-cycle pulse: tick while enabled and empty
//   irq          low-watermark interrupt
//
// Register map: 0 data (W push / R out_port), 1 status (W1C bits 10/11),
// 2 control ([0] enable, [1] flush, [2] irq_en), 3 threshold [7:0].
//
// Optional feature macro: SAMPLE_OUT_IRQ_EN. When undefined, irq is tied 0,
// address 3 reads 0 and ignores writes, and control bit 2 reads 0.
// ---------------------------------------------------------------------------
module nios_audio_sample_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEVEL_W    = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    nios_audio_sample_out_fifo_if.slave   bus,
    input  logic                          sample_tick,
    output logic [DATA_WIDTH-1:0]         out_port,
    output logic                          underrun,
    output logic                          irq
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  enable_q, enable_d;
    logic                  underrun_q, underrun_d;
    logic                  urun_sticky_q, urun_sticky_d;
    logic                  ovf_sticky_q, ovf_sticky_d;

    logic bus_wr, push, flush, ctrl_wr, status_wr, thresh_wr;
    logic empty, full, tick_en, pop, push_ok, ovf_set;
    logic       irq_en_rd;
    logic [7:0] threshold_rd;

    assign bus_wr    = bus.chipselect & ~bus.write_n;
    assign push      = bus_wr & (bus.address == ADDR_DATA);
    assign status_wr = bus_wr & (bus.address == ADDR_STATUS);
    assign ctrl_wr   = bus_wr & (bus.address == ADDR_CTRL);
    assign thresh_wr = bus_wr & (bus.address == ADDR_THRESH);
    assign flush     = ctrl_wr & bus.writedata[1];

    assign empty   = (level_q == '0);
    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign tick_en = sample_tick & enable_q;
    assign pop     = tick_en & ~empty & ~flush;
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    // NOTE: every variable assigned here gets a default first, so no path can leave a latch.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        out_d         = out_q;
        enable_d      = enable_q;
        underrun_d    = 1'b0;
        urun_sticky_d = urun_sticky_q;
        ovf_sticky_d  = ovf_sticky_q;

        if (ctrl_wr) begin
            enable_d = bus.writedata[0];
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            out_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                out_d    = mem_q[rd_ptr_q];
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LEVEL_W'(1);
                2'b01:   level_d = level_q - LEVEL_W'(1);
                default: level_d = level_q;
            endcase
            // An empty FIFO has no bypass: a same-cycle push is stored and the tick still underruns.
            underrun_d = tick_en & empty;
        end

        // Write-1-to-clear, but a new event in the same cycle wins.
        if (status_wr) begin
            urun_sticky_d = urun_sticky_d & ~bus.writedata[10];
            ovf_sticky_d  = ovf_sticky_d  & ~bus.writedata[11];
        end
        if (underrun_d) urun_sticky_d = 1'b1;
        if (ovf_set)    ovf_sticky_d  = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            out_q         <= '0;
            enable_q      <= 1'b0;
            underrun_q    <= 1'b0;
            urun_sticky_q <= 1'b0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            out_q         <= out_d;
            enable_q      <= enable_d;
            underrun_q    <= underrun_d;
            urun_sticky_q <= urun_sticky_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    // NOTE: the storage array has no reset; level and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= bus.writedata[DATA_WIDTH-1:0];
        end
    end

`ifdef SAMPLE_OUT_IRQ_EN
    logic       irq_en_q;
    logic [7:0] threshold_q;
    logic       irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            threshold_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (ctrl_wr)   irq_en_q    <= bus.writedata[2];
            if (thresh_wr) threshold_q <= bus.writedata[7:0];
            // Registered from the current level, so irq trails level by one cycle.
            irq_q <= irq_en_q & enable_q & (8'(level_q) <= threshold_q);
        end
    end

    assign irq          = irq_q;
    assign irq_en_rd    = irq_en_q;
    assign threshold_rd = threshold_q;
`else
    assign irq          = 1'b0;
    assign irq_en_rd    = 1'b0;
    assign threshold_rd = 8'd0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = 32'(out_q);
            ADDR_STATUS: bus.readdata = {20'd0, ovf_sticky_q, urun_sticky_q, full, empty, 8'(level_q)};
            ADDR_CTRL:   bus.readdata = {29'd0, irq_en_rd, 1'b0, enable_q};
            ADDR_THRESH: bus.readdata = {24'd0, threshold_rd};
            default:     bus.readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_nios_audio_sample_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_nios_audio_sample_out_fifo
// Directed bench for nios_audio_sample_out_fifo (DATA_WIDTH=32, DEPTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge or shortly after it, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_nios_audio_sample_out_fifo;
`ifdef SAMPLE_OUT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [31:0] out_port;
    logic        underrun;
    logic        irq;
    logic [31:0] rdata;
    int          tests_run    = 0;
    int          tests_failed = 0;

    nios_audio_sample_out_fifo_if bus();

    nios_audio_sample_out_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sample_tick (sample_tick),
        .out_port    (out_port),
        .underrun    (underrun),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus/tick cycle: drive after a falling edge, release at the next one.
    task automatic cycle(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic tk);
        @(negedge clk);
        bus.chipselect  = wr;
        bus.write_n     = ~wr;
        bus.address     = a;
        bus.writedata   = d;
        sample_tick     = tk;
        @(negedge clk);
        bus.chipselect  = 1'b0;
        bus.write_n     = 1'b1;
        sample_tick     = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        cycle(1'b1, 2'd0, d, 1'b0);
    endtask

    task automatic tick();
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.address = a;
        #1;
        rdata = bus.readdata;
        check(tag, rdata, exp);
    endtask

    initial begin
        reset          = 1'b1;
        sample_tick    = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        #12 reset = 1'b0;

        // Reset state
        check_reg("rst_status", 2'd1, 32'h0000_0100);
        check_reg("rst_data",   2'd0, 32'h0);
        check_reg("rst_ctrl",   2'd2, 32'h0);
        check_reg("rst_thresh", 2'd3, 32'h0);
        check("rst_out_port", out_port, 32'h0);
        check("rst_underrun", {31'd0, underrun}, 32'h0);
        check("rst_irq",      {31'd0, irq},      32'h0);

        // Fill to full, then overflow, then W1C
        for (int i = 0; i < 16; i++) push(32'h11 + 32'(i));
        check_reg("full_status", 2'd1, 32'h0000_0210);
        push(32'hFF);
        check_reg("ovf_status", 2'd1, 32'h0000_0A10);
        wr_reg(2'd1, 32'h0000_0800);
        check_reg("w1c_status", 2'd1, 32'h0000_0210);

        // Full with same-cycle push and tick: accepted, level unchanged
        wr_reg(2'd2, 32'h1);
        cycle(1'b1, 2'd0, 32'h55, 1'b1);
        check("full_pp_out", out_port, 32'h11);
        check_reg("full_pp_status", 2'd1, 32'h0000_0210);
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("drain_%0d", i), out_port, 32'h12 + 32'(i));
        end
        tick();
        check("drain_55", out_port, 32'h55);
        check_reg("drained_status", 2'd1, 32'h0000_0100);

        // Two samples out, then underrun
        push(32'hA);
        push(32'hB);
        tick();
        check("pop_a", out_port, 32'hA);
        tick();
        check("pop_b", out_port, 32'hB);
        tick();
        check("urun_pulse", {31'd0, underrun}, 32'h1);
        check("urun_hold",  out_port, 32'hB);
        @(negedge clk);
        check("urun_one_cycle", {31'd0, underrun}, 32'h0);
        check_reg("urun_status", 2'd1, 32'h0000_0500);
        check_reg("urun_data",   2'd0, 32'h0000_000B);

        // Tick while disabled is ignored
        wr_reg(2'd2, 32'h0);
        push(32'h77);
        tick();
        check("dis_out",      out_port, 32'hB);
        check("dis_underrun", {31'd0, underrun}, 32'h0);
        check_reg("dis_status", 2'd1, 32'h0000_0401);

        // Mid-stream flush at level 5; sticky flags survive
        wr_reg(2'd2, 32'h1);
        for (int i = 0; i < 4; i++) push(32'h21 + 32'(i));
        check_reg("pre_flush", 2'd1, 32'h0000_0405);
        wr_reg(2'd2, 32'h7);
        check("flush_out", out_port, 32'h0);
        check_reg("flush_status", 2'd1, 32'h0000_0500);
        check_reg("flush_ctrl",   2'd2, IRQ_ON ? 32'h5 : 32'h1);
        push(32'h31);
        push(32'h32);
        tick();
        check("post_flush_pop", out_port, 32'h31);
        wr_reg(2'd2, 32'h3);
        check_reg("flush2_status", 2'd1, 32'h0000_0500);

        // Threshold register width / presence
        wr_reg(2'd3, 32'h1FF);
        check_reg("thresh_rd", 2'd3, IRQ_ON ? 32'hFF : 32'h0);
        wr_reg(2'd3, 32'h4);

        // Low-watermark interrupt
        wr_reg(2'd2, 32'h4);
        check_reg("irq_ctrl_a", 2'd2, IRQ_ON ? 32'h4 : 32'h0);
        check("irq_disabled", {31'd0, irq}, 32'h0);
        for (int i = 0; i < 6; i++) push(32'h41 + 32'(i));
        wr_reg(2'd2, 32'h5);
        check_reg("irq_ctrl_b", 2'd2, IRQ_ON ? 32'h5 : 32'h1);
        check("irq_lvl6", {31'd0, irq}, 32'h0);
        tick();
        check("irq_pop1", out_port, 32'h41);
        tick();
        check("irq_pop2", out_port, 32'h42);
        check("irq_lag",  {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
        push(32'h47);
        check("irq_still", {31'd0, irq}, {31'd0, IRQ_ON});
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'h0);
        check_reg("irq_status", 2'd1, 32'h0000_0405);

        // Asynchronous reset in the middle of a push
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'hAA;
        #2 reset = 1'b1;
        #1;
        check("arst_out",      out_port, 32'h0);
        check("arst_underrun", {31'd0, underrun}, 32'h0);
        check("arst_irq",      {31'd0, irq}, 32'h0);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd1;
        #1;
        rdata = bus.readdata;
        check("arst_status", rdata, 32'h0000_0100);
        @(negedge clk);
        reset = 1'b0;
        check_reg("post_rst_status", 2'd1, 32'h0000_0100);
        check_reg("post_rst_ctrl",   2'd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/nios_audio_sample_out_fifo.md
Name: nios_audio_sample_out_fifo

Overview:
Parametrised successor to the single-register Avalon-MM output PIO, for the audio path. The NIOS II pushes samples into an internal FIFO over the Avalon-MM slave. Each `sample_tick` from the audio codec clock domain logic pops one sample onto `out_port`. Status, underrun/overflow flags and an optional low-watermark interrupt let software refill in bursts instead of writing once per sample period.

Parameters:
- DATA_WIDTH, 32, sample width; legal range 1..32. `out_port` width; writedata/readdata are zero-extended above it.
- DEPTH, 16, FIFO entries; power of 2, legal range 2..128.
- LEVEL_W, $clog2(DEPTH)+1, fill-level counter width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational; zero wait states.
- sample_tick  in  1  one-cycle pop strobe, synchronous to clk.
- out_port  out  DATA_WIDTH  current sample.
- underrun  out  1  one-cycle pulse: tick arrived while enabled and empty.
- irq  out  1  low-watermark interrupt (optional feature only; tied 0 otherwise).

Behaviour:
- Access: write = chipselect & ~write_n; read data = f(address), with no read side effects.
- Reset values: out_port=0, FIFO empty, level=0, enable=0, irq_en=0, threshold=0, sticky flags=0, underrun=0, irq=0.
- Register map, address 0:
  - W: push writedata[DATA_WIDTH-1:0].
  - R: out_port, zero-extended.
- Register map, address 1 (status):
  - R: [7:0] level, [8] empty, [9] full, [10] underrun_sticky, [11] overflow_sticky, rest 0.
  - W: write-1-to-clear on bits 10 and 11; other bits ignored.
- Register map, address 2 (control):
  - [0] enable.
  - [1] flush: self-clearing, always reads 0.
  - [2] irq_en.
- Register map, address 3: [7:0] threshold; bits above are ignored and read 0.
- Pop: on sample_tick & enable & ~empty, out_port <= head at that edge (1-cycle latency) and the read pointer advances.
- Tick while enable=0: ignored. No pop, no flag, out_port unchanged.
- Tick while enable=1 & empty: out_port holds its last value, underrun pulses for 1 cycle, underrun_sticky <= 1.
- Push when not full: stored at the write pointer, level+1.
- Push when full with no pop that cycle: data dropped, overflow_sticky <= 1, state otherwise unchanged.
- Push and pop in the same cycle:
  - Level unchanged; both pointers advance.
  - If full, the push is accepted (the pop frees a slot).
  - If empty, there is no bypass: the push is stored and the tick counts as an underrun.
- Pointers: log2(DEPTH) bits, natural wrap. Level is a separate up/down counter from 0 to DEPTH; full = (level==DEPTH), empty = (level==0).
- Flush write (addr 2, bit1=1): next edge empties the FIFO, zeroes both pointers, sets out_port=0. Sticky flags are not touched. Enable and irq_en take bits 0 and 2 of the same write. A push or pop in the flush cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); FIFO contents are don't-care.
- readdata reflects register state before the current edge; a write is visible on the following cycle.

Optional Feature:
- Macro: SAMPLE_OUT_IRQ_EN.
- Defined:
  - irq = irq_en & enable & (level <= threshold), registered, 1-cycle lag from level.
  - Level-sensitive; cleared by refilling above threshold or clearing irq_en.
  - threshold register implemented.
- Undefined:
  - irq tied 0.
  - Address 3 reads 0 and ignores writes.
  - Control bit 2 reads 0.

Test Plan:
- Reset, then read addr 1 -> 0x00000100 (empty). out_port=0, irq=0.
- DEPTH=16: push 0x11..0x20 (16 words), then a 17th push 0xFF -> status reads level=16, full=1, overflow_sticky=1. Write 0x800 to addr 1 -> bit 11 clears.
- enable=1, push 0xA, 0xB, tick twice -> out_port=0xA one cycle after tick 1, 0xB after tick 2. A third tick -> underrun pulses 1 cycle, sticky set, out_port stays 0xB.
- FIFO full plus same-cycle push 0x55 and tick -> level stays 16, no overflow, 0x55 pops after the 15 older entries.
- Macro defined: threshold=4, irq_en=enable=1, push 6, tick 2 -> irq rises 1 cycle after level reaches 4. One push -> irq falls.
- Mid-stream flush with level=5 -> next cycle level=0, out_port=0, sticky flags unchanged. Assert reset mid-push -> all outputs 0 asynchronously.
